// File: rtl/kb_event_queue_pkg.sv
// Shared definitions for the keyboard event queue: entry layout and FSM states.
package kb_event_queue_pkg;

    localparam int KB_ENTRY_W = 13;
    localparam int ASCII_W    = 8;
    localparam int FLAG_W     = 5;
    localparam int ASCII_LSB  = 0;
    localparam int FLAG_LSB   = 8;
    localparam int ERR_BIT    = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } kb_state_e;

    // Pack modifier flags and ascii code into one queue entry.
    function automatic logic [KB_ENTRY_W-1:0] kb_pack(input logic [FLAG_W-1:0]  flags,
                                                     input logic [ASCII_W-1:0] code);
        logic [KB_ENTRY_W-1:0] entry;
        entry = '0;
        entry[FLAG_LSB +: FLAG_W]   = flags;
        entry[ASCII_LSB +: ASCII_W] = code;
        return entry;
    endfunction

endpackage

// File: rtl/kb_event_queue_sync_fifo.sv
// Show-ahead synchronous FIFO: head entry is visible on dout with no read latency.
module kb_event_queue_sync_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));
    assign count = count_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q];

    // Pop only when something is held; a push into a full FIFO succeeds only alongside a pop.
    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; empty masks stale contents on dout.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/kb_event_queue.sv
// Keyboard event queue: turns held-key levels into press/typematic events,
// buffers them, and drives the overflow flag and interrupt.
//
//  state     | meaning
//  ST_IDLE   | no key held; next nonzero ascii is a fresh press
//  ST_DELAY  | key pressed, waiting REPEAT_DELAY cycles for first repeat
//  ST_REPEAT | typematic: one repeat every REPEAT_RATE cycles
module kb_event_queue
    import kb_event_queue_pkg::*;
#(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               ascii,
    input  logic [4:0]               kb_flags,
    input  logic                     rd_pop,
    input  logic                     clr_ovf,
    input  logic                     irq_en,
    output logic [12:0]              dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     irq
);

    localparam logic [31:0] DELAY_TC = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RATE_TC  = 32'(REPEAT_RATE - 1);

    kb_state_e             state_q, state_d;
    logic [31:0]           timer_q, timer_d;
    logic [7:0]            ascii_q, ascii_d;
    logic                  overflow_q, overflow_d;
    logic                  push;
    logic                  full;
    logic [KB_ENTRY_W-1:0] entry;
    logic                  key_held;
    logic                  key_changed;

    assign entry       = kb_pack(kb_flags, ascii);
    assign key_held    = (ascii != 8'd0);
    assign key_changed = (ascii != ascii_q);

    // Press/repeat decision; the push is combinational so a press is queued on the edge it is seen.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q + 32'd1;
        push    = 1'b0;
        if (entry[ERR_BIT]) begin
            state_d = ST_IDLE;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    timer_d = '0;
                    if (key_held) begin
                        push    = 1'b1;
                        state_d = ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (!key_held) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (key_changed) begin
                        push    = 1'b1;
                        timer_d = '0;
                    end else if (timer_q == DELAY_TC) begin
                        push    = 1'b1;
                        state_d = ST_REPEAT;
                        timer_d = '0;
                    end
                end
                ST_REPEAT: begin
                    if (!key_held) begin
                        state_d = ST_IDLE;
                        timer_d = '0;
                    end else if (key_changed) begin
                        push    = 1'b1;
                        state_d = ST_DELAY;
                        timer_d = '0;
                    end else if (timer_q == RATE_TC) begin
                        push    = 1'b1;
                        timer_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped push beats a simultaneous clear. When full, the FIFO
    // cannot also be empty, so rd_pop here always frees a slot.
    always_comb begin
        ascii_d    = ascii;
        overflow_d = overflow_q;
        if (push && full && !rd_pop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    // Controller registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            ascii_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ascii_q    <= ascii_d;
            overflow_q <= overflow_d;
        end
    end

    kb_event_queue_sync_fifo #(
        .WIDTH (KB_ENTRY_W),
        .DEPTH (int'(DEPTH))
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (entry),
        .pop   (rd_pop),
        .dout  (dout),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    assign overflow = overflow_q;
    assign irq      = irq_en & ~empty;

endmodule

// File: tb/tb_kb_event_queue.sv
// Directed bench for kb_event_queue with DEPTH=4, REPEAT_DELAY=8, REPEAT_RATE=4.
module tb_kb_event_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ascii;
    logic [4:0]  kb_flags;
    logic        rd_pop;
    logic        clr_ovf;
    logic        irq_en;
    logic [12:0] dout;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    kb_event_queue #(
        .DEPTH        (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ascii    (ascii),
        .kb_flags (kb_flags),
        .rd_pop   (rd_pop),
        .clr_ovf  (clr_ovf),
        .irq_en   (irq_en),
        .dout     (dout),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .irq      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_once();
        rd_pop = 1'b1;
        tick();
        rd_pop = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        ascii    = 8'h41;
        kb_flags = 5'd0;
        rd_pop   = 1'b0;
        clr_ovf  = 1'b0;
        irq_en   = 1'b0;

        // Reset with a key held.
        tick(2);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_count", 32'(count), 32'd1);
        chk("rel_dout", 32'(dout), 32'h041);
        ascii = 8'h00;
        tick();
        pop_once();
        chk("rel_pop_empty", 32'(empty), 32'd1);

        // Tap: one entry only.
        ascii = 8'h61;
        tick(3);
        ascii = 8'h00;
        tick(2);
        chk("tap_count", 32'(count), 32'd1);
        chk("tap_dout", 32'(dout), 32'h061);
        pop_once();
        chk("tap_pop_count", 32'(count), 32'd0);
        chk("tap_pop_empty", 32'(empty), 32'd1);

        // Typematic: pushes at edges 0, 8, 12, 16.
        ascii = 8'h62;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0 || i == 7)   chk($sformatf("rep_cnt_%0d", i), 32'(count), 32'd1);
            if (i == 8 || i == 11)  chk($sformatf("rep_cnt_%0d", i), 32'(count), 32'd2);
            if (i == 12 || i == 15) chk($sformatf("rep_cnt_%0d", i), 32'(count), 32'd3);
            if (i == 16 || i == 19) chk($sformatf("rep_cnt_%0d", i), 32'(count), 32'd4);
        end
        chk("rep_no_ovf", 32'(overflow), 32'd0);
        tick();
        chk("rep5_ovf", 32'(overflow), 32'd1);
        chk("rep5_count", 32'(count), 32'd4);
        ascii = 8'h00;
        tick();

        // Overflow handling.
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        ascii = 8'h63;
        tick();
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_count", 32'(count), 32'd4);
        chk("drop_head", 32'(dout), 32'h062);
        ascii = 8'h00;
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf2", 32'(overflow), 32'd0);
        rd_pop = 1'b1;
        ascii  = 8'h64;
        tick();
        rd_pop = 1'b0;
        chk("pp_full_count", 32'(count), 32'd4);
        chk("pp_full_ovf", 32'(overflow), 32'd0);
        ascii = 8'h00;
        tick();
        clr_ovf = 1'b1;
        ascii   = 8'h65;
        tick();
        clr_ovf = 1'b0;
        ascii   = 8'h00;
        chk("set_wins", 32'(overflow), 32'd1);
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("drain_head0", 32'(dout), 32'h062);
        pop_once();
        chk("drain_head1", 32'(dout), 32'h062);
        pop_once();
        chk("drain_head2", 32'(dout), 32'h062);
        pop_once();
        chk("drain_head3", 32'(dout), 32'h064);
        pop_once();
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_dout0", 32'(dout), 32'h0);

        // Key change and error, with shift flag held.
        kb_flags = 5'b00001;
        ascii    = 8'h41;
        tick(6);
        ascii = 8'h42;
        tick();
        chk("chg_count", 32'(count), 32'd2);
        tick(7);
        chk("chg_pre_rep", 32'(count), 32'd2);
        tick();
        chk("chg_rep", 32'(count), 32'd3);
        kb_flags = 5'b10001;
        tick(10);
        chk("err_nopush", 32'(count), 32'd3);
        kb_flags = 5'b00001;
        tick();
        chk("err_repress", 32'(count), 32'd4);
        ascii    = 8'h00;
        kb_flags = 5'd0;
        tick();
        chk("chg_head0", 32'(dout), 32'h141);
        pop_once();
        chk("chg_head1", 32'(dout), 32'h142);
        pop_once();
        chk("chg_head2", 32'(dout), 32'h142);
        pop_once();
        chk("chg_head3", 32'(dout), 32'h142);
        pop_once();
        chk("chg_empty", 32'(empty), 32'd1);

        // Interrupt.
        ascii = 8'h70;
        tick();
        ascii = 8'h00;
        tick();
        chk("irq_dis", 32'(irq), 32'd0);
        irq_en = 1'b1;
        #1;
        chk("irq_en", 32'(irq), 32'd1);
        pop_once();
        chk("irq_after_pop", 32'(irq), 32'd0);
        pop_once();
        chk("pop_empty_count", 32'(count), 32'd0);
        chk("pop_empty_flag", 32'(empty), 32'd1);

        // Push and pop together on an empty FIFO: push only.
        rd_pop = 1'b1;
        ascii  = 8'h71;
        tick();
        rd_pop = 1'b0;
        ascii  = 8'h00;
        chk("pp_empty_count", 32'(count), 32'd1);
        chk("pp_empty_dout", 32'(dout), 32'h071);
        chk("pp_empty_irq", 32'(irq), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
